spi_host_fifo: RTL and testbench

- Byte-wide CPU-bus to SPI master bridge with TX/RX FIFOs, a programmable SCK divider, all four SPI modes, and automatic or manual chip-select.
- Sits between the Z80/6809 CPU bus decode and the off-chip SPI peripheral (USB host controller, SD, flash).
- The 4-register map keeps status bit0 "data ready" so existing polling drivers still work.

---
 rtl/spi_host_fifo.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_spi_host_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_fifo.sv
// rtl/spi_host_fifo.sv - Byte-wide CPU bus to SPI master bridge with TX/RX FIFOs
//
// spi_host_fifo_q : synchronous FIFO, push side in_*, pop side out_* (tvalid = non-empty,
//                   tready = pop), plus full flag and a clear that empties it in one cycle.
// spi_host_fifo   : top level.
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   rd, wr     one-cycle read / write strobes
//   a[1:0]     register select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV
//   din[7:0]   write data
//   dout[7:0]  read data, combinational while rd=1, else 8'h00
//   sck, sdcs, sdo, sdi   SPI clock, chip select (active low), MOSI, MISO

module spi_host_fifo_q #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         in_tvalid,
    input  logic [W-1:0] in_tdata,
    output logic         out_tvalid,
    input  logic         out_tready,
    output logic [W-1:0] out_tdata,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full       = (cnt == FULL_CNT);
    assign out_tvalid = (cnt != '0);
    assign out_tdata  = mem[rp];
    assign do_pop     = out_tready && out_tvalid;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign do_push    = in_tvalid && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= in_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module spi_host_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd,
    input  logic       wr,
    input  logic [1:0] a,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       sck,
    output logic       sdcs,
    output logic       sdo,
    input  logic       sdi
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic       ctrl_cpol;
    logic       ctrl_cpha;
    logic       ctrl_manual;
    logic       ctrl_cs_level;
    logic [7:0] div_reg;
    logic       overrun;

    logic [2:0] state;
    logic [7:0] cnt;
    logic [3:0] hcnt;
    logic       cpha_l;
    logic [7:0] div_l;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       sck_q;
    logic       cs_q;
    logic       sdo_q;

    logic       wr_data;
    logic       wr_ctrl;
    logic       wr_div;
    logic       rd_data;
    logic       rd_stat;
    logic       flush;

    logic       tx_valid;
    logic [7:0] tx_head;
    logic       tx_full;
    logic       rx_valid;
    logic [7:0] rx_head;
    logic       rx_full;
    logic       rx_push;
    logic       rx_drop;

    logic       load;
    logic       half_done;
    logic       edge_now;
    logic       edge_lead;
    logic       shift_out;
    logic       sample;
    logic       busy;
    logic [7:0] status;
    logic [7:0] ctrl_rd;

    assign wr_data = wr && (a == 2'd0);
    assign wr_ctrl = wr && (a == 2'd2);
    assign wr_div  = wr && (a == 2'd3);
    assign rd_data = rd && (a == 2'd0);
    assign rd_stat = rd && (a == 2'd1);
    assign flush   = wr_ctrl && din[7];

    // The engine takes a new byte from IDLE, or from NEXT to chain bytes under one CS.
    assign load    = tx_valid && ((state == ST_IDLE) || (state == ST_NEXT));
    assign rx_push = (state == ST_NEXT);
    // RX full is only a drop if the CPU is not popping in the same cycle.
    assign rx_drop = rx_push && rx_full && !(rd_data && rx_valid);

    spi_host_fifo_q #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_q (
        .clk        (clk),
        .resetn     (reset),
        .clear      (flush),
        .in_tvalid  (wr_data),
        .in_tdata   (din),
        .out_tvalid (tx_valid),
        .out_tready (load),
        .out_tdata  (tx_head),
        .full       (tx_full)
    );

    spi_host_fifo_q #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_q (
        .clk        (clk),
        .resetn     (reset),
        .clear      (flush),
        .in_tvalid  (rx_push),
        .in_tdata   (rx_sr),
        .out_tvalid (rx_valid),
        .out_tready (rd_data),
        .out_tdata  (rx_head),
        .full       (rx_full)
    );

    // SCK edges: the end of SETUP is edge 0 (leading); in SHIFT, the end of half
    // hcnt is edge hcnt+1, so edges are leading when hcnt is odd. The end of the
    // last half (hcnt=15) has no edge, sck has already returned to CPOL.
    assign half_done = (cnt == div_l);
    assign edge_now  = half_done && ((state == ST_SETUP) ||
                                     ((state == ST_SHIFT) && (hcnt != 4'd15)));
    assign edge_lead = (state == ST_SETUP) ? 1'b1 : hcnt[0];
    assign shift_out = edge_now && (edge_lead == cpha_l);
    assign sample    = edge_now && (edge_lead != cpha_l);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_cpol     <= 1'b0;
            ctrl_cpha     <= 1'b0;
            ctrl_manual   <= 1'b0;
            ctrl_cs_level <= 1'b0;
            div_reg       <= 8'(CLK_DIV);
        end else begin
            if (wr_ctrl) begin
                ctrl_cpol     <= din[0];
                ctrl_cpha     <= din[1];
                ctrl_manual   <= din[2];
                ctrl_cs_level <= din[3];
            end
            if (wr_div) begin
                div_reg <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (rx_drop) begin
            overrun <= 1'b1;
        end else if (rd_stat) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= 8'd0;
            hcnt   <= 4'd0;
            cpha_l <= 1'b0;
            div_l  <= 8'd0;
            tx_sr  <= 8'd0;
            rx_sr  <= 8'd0;
            sck_q  <= 1'b0;
            cs_q   <= 1'b1;
            sdo_q  <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
            hcnt  <= 4'd0;
            cs_q  <= 1'b1;
            sck_q <= din[0];
        end else begin
            case (state)
                ST_IDLE: begin
                    sck_q <= ctrl_cpol;
                    cs_q  <= 1'b1;
                end
                ST_SETUP: begin
                    if (half_done) begin
                        cnt   <= 8'd0;
                        hcnt  <= 4'd0;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (half_done) begin
                        cnt <= 8'd0;
                        if (hcnt == 4'd15) begin
                            state <= ST_NEXT;
                        end else begin
                            hcnt <= hcnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_NEXT: begin
                    cnt   <= 8'd0;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (half_done) begin
                        cnt   <= 8'd0;
                        cs_q  <= 1'b1;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (half_done) begin
                        cnt   <= 8'd0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 8'd0;
                end
            endcase

            if (edge_now) begin
                sck_q <= ~sck_q;
            end
            if (shift_out) begin
                sdo_q <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (sample) begin
                rx_sr <= {rx_sr[6:0], sdi};
            end

            // Loading overrides the NEXT->HOLD default above. With CPHA=0 the MSB
            // goes out immediately, so the shifter keeps only the remaining bits.
            if (load) begin
                state  <= ST_SETUP;
                cnt    <= 8'd0;
                cpha_l <= ctrl_cpha;
                div_l  <= div_reg;
                sck_q  <= ctrl_cpol;
                cs_q   <= 1'b0;
                if (ctrl_cpha) begin
                    tx_sr <= tx_head;
                end else begin
                    tx_sr <= {tx_head[6:0], 1'b0};
                    sdo_q <= tx_head[7];
                end
            end
        end
    end

    assign busy    = (state != ST_IDLE) || tx_valid;
    assign status  = {3'b000, !tx_valid, overrun, busy, tx_full, rx_valid};
    assign ctrl_rd = {4'b0000, ctrl_cs_level, ctrl_manual, ctrl_cpha, ctrl_cpol};

    always_comb begin
        dout = 8'h00;
        if (rd) begin
            case (a)
                2'd0:    dout = rx_valid ? rx_head : 8'h00;
                2'd1:    dout = status;
                2'd2:    dout = ctrl_rd;
                default: dout = div_reg;
            endcase
        end
    end

    assign sck  = sck_q;
    assign sdo  = sdo_q;
    assign sdcs = ctrl_manual ? !ctrl_cs_level : cs_q;
endmodule

// File: tb/tb_spi_host_fifo.sv
// tb/tb_spi_host_fifo.sv - Directed self-checking bench for spi_host_fifo
module tb_spi_host_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       rd;
    logic       wr;
    logic [1:0] a;
    logic [7:0] din;
    logic [7:0] dout;
    logic       sck;
    logic       sdcs;
    logic       sdo;
    logic       sdi;
    logic       loop_en;
    logic       sdi_fix;

    int checks = 0;
    int errors = 0;
    int sck_rises = 0;

    assign sdi = loop_en ? sdo : sdi_fix;

    spi_host_fifo #(.FIFO_DEPTH(4), .CLK_DIV(3)) dut (
        .clk  (clk),
        .reset(reset),
        .rd   (rd),
        .wr   (wr),
        .a    (a),
        .din  (din),
        .dout (dout),
        .sck  (sck),
        .sdcs (sdcs),
        .sdo  (sdo),
        .sdi  (sdi)
    );

    always #5 clk = ~clk;

    always @(posedge sck) sck_rises <= sck_rises + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    // All bus tasks start and end on a falling clk edge.
    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        wr = 1'b1; a = addr; din = data;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] d);
        rd = 1'b1; a = addr;
        #1 d = dout;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL rst_sck got=%b exp=0", sck); end
        checks++; if (sdcs !== 1'b1) begin errors++; $display("FAIL rst_sdcs got=%b exp=1", sdcs); end
        checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL rst_sdo got=%b exp=0", sdo); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout got=%h exp=00", dout); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL rst_status got=%h exp=10", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL rst_div got=%h exp=03", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_ctrl got=%h exp=00", d); end
    endtask

    task automatic test_mode0();
        logic [7:0] d;
        logic [7:0] got = 8'h00;
        int nbits = 0;
        logic prev;
        loop_en = 1'b1;
        bus_write(2'd3, 8'h00);
        bus_write(2'd2, 8'h00);
        repeat (2) @(negedge clk);
        bus_write(2'd0, 8'hA5);
        prev = sck;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                checks++; if (sdcs !== 1'b1) begin errors++; $display("FAIL m0_cs_n1 got=%b exp=1", sdcs); end
            end
            if (i == 1) begin
                checks++; if (sdcs !== 1'b0) begin errors++; $display("FAIL m0_cs_n2 got=%b exp=0", sdcs); end
            end
            if (!prev && sck && nbits < 8) begin
                got = {got[6:0], sdo};
                nbits++;
            end
            prev = sck;
            @(negedge clk);
        end
        checks++; if (nbits !== 8) begin errors++; $display("FAIL m0_nbits got=%0d exp=8", nbits); end
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL m0_sdo_bits got=%h exp=a5", got); end
        checks++; if (sdcs !== 1'b1) begin errors++; $display("FAIL m0_cs_end got=%b exp=1", sdcs); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL m0_status got=%h exp=11", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL m0_rx got=%h exp=a5", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL m0_status2 got=%h exp=10", d); end
    endtask

    task automatic test_mode3();
        logic [7:0] d;
        int stamps[32];
        int nt = 0;
        int bad = 0;
        int cs_rose = 0;
        bit fell = 0;
        logic prev;
        loop_en = 1'b1;
        bus_write(2'd3, 8'h02);
        bus_write(2'd2, 8'h03);
        repeat (2) @(negedge clk);
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL m3_idle_sck got=%b exp=1", sck); end
        bus_write(2'd0, 8'h3C);
        bus_write(2'd0, 8'hC3);
        prev = sck;
        for (int i = 0; i < 160; i++) begin
            if (sck !== prev) begin
                if (nt < 32) stamps[nt] = i;
                nt++;
            end
            prev = sck;
            if (sdcs === 1'b0) fell = 1;
            else if (fell && nt < 32) cs_rose++;
            @(negedge clk);
        end
        checks++; if (nt !== 32) begin errors++; $display("FAIL m3_edges got=%0d exp=32", nt); end
        if (nt >= 32) begin
            for (int k = 1; k < 32; k++) begin
                if (k != 16 && stamps[k] - stamps[k-1] != 3) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL m3_half_period got=%0d_bad exp=0", bad); end
            checks++; if (stamps[16] - stamps[15] !== 7) begin errors++; $display("FAIL m3_byte_gap got=%0d exp=7", stamps[16] - stamps[15]); end
        end
        checks++; if (fell !== 1'b1 || cs_rose !== 0) begin errors++; $display("FAIL m3_cs_low got=fell%0d_rose%0d exp=fell1_rose0", fell, cs_rose); end
        checks++; if (sdcs !== 1'b1 || sck !== 1'b1) begin errors++; $display("FAIL m3_end got=cs%b_sck%b exp=cs1_sck1", sdcs, sck); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL m3_rx0 got=%h exp=3c", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL m3_rx1 got=%h exp=c3", d); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        int r0;
        int nff = 0;
        loop_en = 1'b0;
        sdi_fix = 1'b1;
        bus_write(2'd2, 8'h00);
        bus_write(2'd3, 8'h00);
        repeat (2) @(negedge clk);
        r0 = sck_rises;
        bus_write(2'd0, 8'h11);
        bus_write(2'd0, 8'h22);
        bus_write(2'd0, 8'h33);
        bus_write(2'd0, 8'h44);
        bus_write(2'd0, 8'h55);
        bus_read(2'd1, d);
        checks++; if (d !== 8'h06) begin errors++; $display("FAIL ov_txfull_status got=%h exp=06", d); end
        bus_write(2'd0, 8'h66);
        repeat (200) @(negedge clk);
        checks++; if (sck_rises - r0 !== 40) begin errors++; $display("FAIL ov_sck_rises got=%0d exp=40", sck_rises - r0); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h19) begin errors++; $display("FAIL ov_status got=%h exp=19", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL ov_cleared got=%h exp=11", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ov_rx_first got=%h exp=ff", d); end
        for (int i = 0; i < 3; i++) begin
            bus_read(2'd0, d);
            if (d === 8'hFF) nff++;
        end
        checks++; if (nff !== 3) begin errors++; $display("FAIL ov_rx_rest got=%0d exp=3", nff); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ov_rx_empty got=%h exp=00", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL ov_status_end got=%h exp=10", d); end
    endtask

    task automatic test_manual_cs();
        logic [7:0] d;
        int highs = 0;
        loop_en = 1'b1;
        bus_write(2'd2, 8'h0C);
        checks++; if (sdcs !== 1'b0) begin errors++; $display("FAIL man_cs_on got=%b exp=0", sdcs); end
        bus_write(2'd0, 8'h5A);
        bus_write(2'd0, 8'h81);
        for (int i = 0; i < 80; i++) begin
            if (sdcs !== 1'b0) highs++;
            @(negedge clk);
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL man_cs_held got=%0d_high exp=0", highs); end
        bus_write(2'd2, 8'h04);
        checks++; if (sdcs !== 1'b1) begin errors++; $display("FAIL man_cs_off got=%b exp=1", sdcs); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL man_rx0 got=%h exp=5a", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h81) begin errors++; $display("FAIL man_rx1 got=%h exp=81", d); end
        bus_write(2'd2, 8'h00);
    endtask

    task automatic test_abort_reset();
        logic [7:0] d;
        bus_write(2'd3, 8'h03);
        bus_write(2'd0, 8'hF0);
        repeat (38) @(negedge clk);
        checks++; if (sdcs !== 1'b0) begin errors++; $display("FAIL ar_active got=%b exp=0", sdcs); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (sdcs !== 1'b1 || sck !== 1'b0) begin errors++; $display("FAIL ar_pins got=cs%b_sck%b exp=cs1_sck0", sdcs, sck); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL ar_status got=%h exp=10", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL ar_rx got=%h exp=00", d); end
        repeat (100) @(negedge clk);
        bus_read(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL ar_status_late got=%h exp=10", d); end
    endtask

    task automatic test_flush();
        logic [7:0] d;
        bus_write(2'd0, 8'hA1);
        bus_write(2'd0, 8'hB2);
        repeat (30) @(negedge clk);
        checks++; if (sdcs !== 1'b0) begin errors++; $display("FAIL fl_active got=%b exp=0", sdcs); end
        bus_write(2'd2, 8'h80);
        checks++; if (sdcs !== 1'b1) begin errors++; $display("FAIL fl_cs got=%b exp=1", sdcs); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL fl_status got=%h exp=10", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL fl_ctrl got=%h exp=00", d); end
        repeat (120) @(negedge clk);
        bus_read(2'd1, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL fl_status_late got=%h exp=10", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL fl_rx got=%h exp=00", d); end
        checks++; if (sdcs !== 1'b1) begin errors++; $display("FAIL fl_cs_late got=%b exp=1", sdcs); end
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; a = 2'd0; din = 8'h00;
        loop_en = 1'b1; sdi_fix = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_mode0();
        test_mode3();
        test_overrun();
        test_manual_cs();
        test_abort_reset();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
